// File: rtl/port_uart_tx.sv
// rtl/port_uart_tx.sv - toggle-handshake port register feeding a 4-deep FIFO and 8N1 UART serializer
module port_uart_tx #(
   parameter int CLOCKS_PER_BIT = 434
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] portOutputWord,
   output logic [31:0] portInputWord,
   output logic        txd
);

   localparam int CNT_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLOCKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } txState_t;

   txState_t         state;
   logic [CNT_W-1:0] bitCounter;
   logic [2:0]       bitIndex;
   logic [7:0]       shiftReg;

   logic [7:0]       fifoMem [4];
   logic [1:0]       wrPtr;
   logic [1:0]       rdPtr;
   logic [2:0]       fifoCount;
   logic             ackToggle;

   logic             requestPending;
   logic             fifoFull;
   logic             fifoEmpty;
   logic             pushNow;
   logic             popNow;
   logic             lastTick;
   logic             frameDone;
   logic             activeNext;
   logic             ackNext;
   logic [2:0]       countNext;
   logic [31:0]      statusNext;
   logic             unusedBits;

   assign unusedBits = ^portOutputWord[30:8];

   // Fullness and emptiness come from the pre-edge count, so a push never
   // rides on a same-cycle pop and a fresh push is never popped on its own edge.
   assign requestPending = portOutputWord[31] != ackToggle;
   assign fifoFull       = fifoCount == 3'd4;
   assign fifoEmpty      = fifoCount == 3'd0;
   assign pushNow        = requestPending && !fifoFull;
   assign lastTick       = bitCounter == LAST_TICK;
   assign popNow         = !fifoEmpty && ((state == IDLE) || (state == STOP && lastTick));
   assign frameDone      = (state == STOP) && lastTick && fifoEmpty;

   always_comb begin
      countNext = fifoCount;
      case ({pushNow, popNow})
         2'b10:   countNext = fifoCount + 3'd1;
         2'b01:   countNext = fifoCount - 3'd1;
         default: countNext = fifoCount;
      endcase
   end

   assign ackNext    = pushNow ? portOutputWord[31] : ackToggle;
   assign activeNext = popNow || ((state != IDLE) && !frameDone);
   assign statusNext = {ackNext, 25'd0, countNext, countNext == 3'd0,
                        countNext == 3'd4, (countNext != 3'd0) || activeNext};

   always_ff @(posedge clock) begin
      if (pushNow) begin
         fifoMem[wrPtr] <= portOutputWord[7:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr     <= 2'd0;
         rdPtr     <= 2'd0;
         fifoCount <= 3'd0;
         ackToggle <= 1'b0;
      end else begin
         if (pushNow) begin
            wrPtr     <= wrPtr + 2'd1;
            ackToggle <= portOutputWord[31];
         end
         if (popNow) begin
            rdPtr <= rdPtr + 2'd1;
         end
         fifoCount <= countNext;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         portInputWord <= 32'h0000_0004;
      end else begin
         portInputWord <= statusNext;
      end
   end

   // txd is loaded on each state transition, so it already carries the new bit
   // during the first cycle of every bit period.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bitCounter <= '0;
         bitIndex   <= 3'd0;
         shiftReg   <= 8'd0;
         txd        <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               txd        <= 1'b1;
               bitCounter <= '0;
               bitIndex   <= 3'd0;
               if (popNow) begin
                  shiftReg <= fifoMem[rdPtr];
                  txd      <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (lastTick) begin
                  bitCounter <= '0;
                  bitIndex   <= 3'd0;
                  txd        <= shiftReg[0];
                  state      <= DATA;
               end else begin
                  bitCounter <= bitCounter + 1'b1;
               end
            end
            DATA: begin
               if (lastTick) begin
                  bitCounter <= '0;
                  if (bitIndex == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     bitIndex <= bitIndex + 3'd1;
                     shiftReg <= {1'b0, shiftReg[7:1]};
                     txd      <= shiftReg[1];
                  end
               end else begin
                  bitCounter <= bitCounter + 1'b1;
               end
            end
            STOP: begin
               if (lastTick) begin
                  bitCounter <= '0;
                  bitIndex   <= 3'd0;
                  if (popNow) begin
                     shiftReg <= fifoMem[rdPtr];
                     txd      <= 1'b0;
                     state    <= START;
                  end else begin
                     txd   <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  bitCounter <= bitCounter + 1'b1;
               end
            end
            default: begin
               txd   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_port_uart_tx.sv
// tb/tb_port_uart_tx.sv - randomized self-checking bench for port_uart_tx with a line-level frame model
module tb_port_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic        clock;
   logic        reset;
   logic [31:0] portOutputWord;
   logic [31:0] portInputWord;
   logic        txd;

   int          nChecks;
   int          nFails;
   logic        lineLog[$];
   logic [7:0]  expBytes[$];
   logic [31:0] lastStatus;
   logic        nextTog;
   logic        expTog;

   port_uart_tx #(.CLOCKS_PER_BIT(CPB)) dut (
      .clock(clock),
      .reset(reset),
      .portOutputWord(portOutputWord),
      .portInputWord(portInputWord),
      .txd(txd)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Status word as the CPU should see it, built from the field definitions.
   function automatic logic [31:0] statusWord(input logic ack, input int count, input logic active);
      logic [31:0] w;
      w      = 32'd0;
      w[31]  = ack;
      w[5:3] = 3'(count);
      w[2]   = (count == 0);
      w[1]   = (count == 4);
      w[0]   = (count != 0) || active;
      return w;
   endfunction

   // Ideal 8N1 line level t cycles after the first start bit of back-to-back frames.
   function automatic logic expBit(input int t);
      int frame;
      int period;
      logic [7:0] b;
      if (t >= expBytes.size() * FRAME) return 1'b1;
      frame  = t / FRAME;
      period = (t % FRAME) / CPB;
      if (period == 0) return 1'b0;
      if (period == 9) return 1'b1;
      b = expBytes[frame];
      return b[period - 1];
   endfunction

   function automatic int firstZero();
      for (int i = 0; i < lineLog.size(); i++) begin
         if (lineLog[i] === 1'b0) return i;
      end
      return -1;
   endfunction

   function automatic int lineErrors(input int start);
      int errs;
      errs = 0;
      if (start < 0 || lineLog.size() < start + expBytes.size() * FRAME) return 9999;
      for (int t = 0; start + t < lineLog.size(); t++) begin
         if (lineLog[start + t] !== expBit(t)) errs++;
      end
      return errs;
   endfunction

   task automatic step();
      @(negedge clock);
      lineLog.push_back(txd);
      lastStatus = portInputWord;
   endtask

   task automatic doWrite(input logic [7:0] data);
      portOutputWord = {nextTog, 23'd0, data};
      expTog         = nextTog;
      nextTog        = ~nextTog;
      expBytes.push_back(data);
   endtask

   task automatic test_reset();
      portOutputWord = 32'd0;
      reset          = 1'b0;
      #2 reset = 1'b1;
      #1;
      nChecks++;
      if (txd !== 1'b1) begin
         nFails++; $display("FAIL reset_txd_async: got %b want 1", txd);
      end
      nChecks++;
      if (portInputWord !== 32'h0000_0004) begin
         nFails++; $display("FAIL reset_status_async: got %h want 00000004", portInputWord);
      end
      step();
      step();
      nChecks++;
      if (lastStatus !== 32'h0000_0004 || txd !== 1'b1) begin
         nFails++; $display("FAIL reset_held: status %h txd %b want 00000004 1", lastStatus, txd);
      end
      reset   = 1'b0;
      nextTog = 1'b1;
      expTog  = 1'b0;
   endtask

   task automatic test_single();
      int fz;
      int errs;
      lineLog.delete();
      expBytes.delete();
      doWrite(8'h55);
      step();
      nChecks++;
      if (lastStatus !== statusWord(1'b1, 1, 1'b0)) begin
         nFails++; $display("FAIL single_ack_next_cycle: got %h want %h", lastStatus, statusWord(1'b1, 1, 1'b0));
      end
      for (int i = 0; i < 55; i++) step();
      fz = firstZero();
      nChecks++;
      if (fz !== 1) begin
         nFails++; $display("FAIL single_start_latency: got %0d want 1", fz);
      end
      errs = lineErrors(fz);
      nChecks++;
      if (errs !== 0) begin
         nFails++; $display("FAIL single_frame_waveform: %0d bad cycles want 0", errs);
      end
      nChecks++;
      if (lastStatus !== statusWord(expTog, 0, 1'b0)) begin
         nFails++; $display("FAIL single_final_status: got %h want %h", lastStatus, statusWord(expTog, 0, 1'b0));
      end
   endtask

   task automatic test_back_to_back();
      int fz;
      int errs;
      lineLog.delete();
      expBytes.delete();
      doWrite(8'h01);
      step();
      doWrite(8'h80);
      for (int i = 0; i < 2 * FRAME + 20; i++) step();
      fz = firstZero();
      nChecks++;
      if (fz !== 1) begin
         nFails++; $display("FAIL b2b_start_latency: got %0d want 1", fz);
      end
      errs = lineErrors(fz);
      nChecks++;
      if (errs !== 0) begin
         nFails++; $display("FAIL b2b_contiguous_frames: %0d bad cycles want 0", errs);
      end
      nChecks++;
      if (lastStatus !== statusWord(expTog, 0, 1'b0)) begin
         nFails++; $display("FAIL b2b_final_status: got %h want %h", lastStatus, statusWord(expTog, 0, 1'b0));
      end
   endtask

   task automatic test_fifo_full();
      int fz;
      int errs;
      int acceptAt;
      logic staleTog;
      logic [31:0] beforePop;
      logic [31:0] afterAccept;
      lineLog.delete();
      expBytes.delete();
      doWrite(8'($urandom));
      for (int i = 1; i < 5; i++) begin
         step();
         doWrite(8'($urandom));
      end
      step();
      nChecks++;
      if (lastStatus !== statusWord(expTog, 4, 1'b1)) begin
         nFails++; $display("FAIL full_after_write5: got %h want %h", lastStatus, statusWord(expTog, 4, 1'b1));
      end
      staleTog = expTog;
      doWrite(8'($urandom));
      acceptAt    = -1;
      beforePop   = 32'd0;
      afterAccept = 32'd0;
      for (int j = 5; j < 6 * FRAME + 30; j++) begin
         step();
         if (j == FRAME + 1) beforePop = lastStatus;
         if (acceptAt < 0 && lastStatus[31] === expTog) begin
            acceptAt    = j;
            afterAccept = lastStatus;
         end
      end
      nChecks++;
      if (beforePop !== statusWord(staleTog, 3, 1'b1)) begin
         nFails++; $display("FAIL full_stop_pop_rejects_push: got %h want %h", beforePop, statusWord(staleTog, 3, 1'b1));
      end
      nChecks++;
      if (acceptAt !== FRAME + 2) begin
         nFails++; $display("FAIL full_write6_accept_cycle: got %0d want %0d", acceptAt, FRAME + 2);
      end
      nChecks++;
      if (afterAccept !== statusWord(expTog, 4, 1'b1)) begin
         nFails++; $display("FAIL full_write6_accept_status: got %h want %h", afterAccept, statusWord(expTog, 4, 1'b1));
      end
      fz = firstZero();
      errs = lineErrors(fz);
      nChecks++;
      if (fz !== 1 || errs !== 0) begin
         nFails++; $display("FAIL full_six_frames_in_order: start %0d bad cycles %0d want 1 0", fz, errs);
      end
      nChecks++;
      if (lastStatus !== statusWord(expTog, 0, 1'b0)) begin
         nFails++; $display("FAIL full_final_status: got %h want %h", lastStatus, statusWord(expTog, 0, 1'b0));
      end
   endtask

   task automatic test_no_toggle();
      lineLog.delete();
      for (int i = 0; i < 30; i++) begin
         portOutputWord = {expTog, 23'($urandom), 8'($urandom)};
         step();
      end
      nChecks++;
      if (firstZero() !== -1) begin
         nFails++; $display("FAIL notoggle_line_idle: first low at %0d want -1", firstZero());
      end
      nChecks++;
      if (lastStatus !== statusWord(expTog, 0, 1'b0)) begin
         nFails++; $display("FAIL notoggle_status: got %h want %h", lastStatus, statusWord(expTog, 0, 1'b0));
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] firstByte;
      lineLog.delete();
      expBytes.delete();
      firstByte = 8'($urandom);
      doWrite(firstByte);
      step();
      doWrite(8'($urandom));
      step();
      doWrite(8'($urandom));
      step();
      nChecks++;
      if (lastStatus !== statusWord(expTog, 2, 1'b1)) begin
         nFails++; $display("FAIL midreset_two_queued: got %h want %h", lastStatus, statusWord(expTog, 2, 1'b1));
      end
      for (int i = 0; i < 17; i++) step();
      nChecks++;
      if (txd !== firstByte[3]) begin
         nFails++; $display("FAIL midreset_data_bit3: got %b want %b", txd, firstByte[3]);
      end
      #1 reset = 1'b1;
      #1;
      nChecks++;
      if (txd !== 1'b1 || portInputWord !== 32'h0000_0004) begin
         nFails++; $display("FAIL midreset_async_abort: txd %b status %h want 1 00000004", txd, portInputWord);
      end
      portOutputWord = 32'd0;
      step();
      step();
      reset   = 1'b0;
      nextTog = 1'b1;
      expTog  = 1'b0;
      lineLog.delete();
      for (int i = 0; i < 2 * FRAME; i++) step();
      nChecks++;
      if (firstZero() !== -1 || lastStatus !== 32'h0000_0004) begin
         nFails++; $display("FAIL midreset_queue_discarded: first low %0d status %h want -1 00000004", firstZero(), lastStatus);
      end
   endtask

   initial begin
      nChecks        = 0;
      nFails         = 0;
      reset          = 1'b0;
      portOutputWord = 32'd0;
      nextTog        = 1'b1;
      expTog         = 1'b0;
      lastStatus     = 32'd0;
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_no_toggle();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
